// File: rtl/write_back_stage_if.sv
// write_back_stage_if
//   Bundles every signal crossing the MEM -> WB boundary, except clock
//   and reset, into one interface.
//   master : the MEM side. It drives the control bits, data fields and
//            Stall/Flush, and it sees the register-file and HI/LO outputs.
//   slave  : the write-back stage. It consumes the MEM fields and drives
//            WriteData, WriteRegister_WB, RegWrite_WB, HI and LO.
interface write_back_stage_if;

  // Pipeline control
  logic        Stall;
  logic        Flush;

  // Instruction fields leaving MEM
  logic        RegWrite_MEM;
  logic        MemtoReg_MEM;
  logic        mthi_MEM;
  logic        mtlo_MEM;
  logic        mfhi_MEM;
  logic        mflo_MEM;
  logic        HiLoWrite_MEM;
  logic [31:0] ALUResult_MEM;
  logic [31:0] MemReadData_MEM;
  logic [63:0] Product_MEM;
  logic [4:0]  WriteRegister_MEM;

  // Register-file write port and architectural HI/LO
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister_WB;
  logic        RegWrite_WB;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Stall, Flush,
    output RegWrite_MEM, MemtoReg_MEM, mthi_MEM, mtlo_MEM, mfhi_MEM, mflo_MEM,
    output HiLoWrite_MEM, ALUResult_MEM, MemReadData_MEM, Product_MEM,
    output WriteRegister_MEM,
    input  WriteData, WriteRegister_WB, RegWrite_WB, HI, LO
  );

  modport slave (
    input  Stall, Flush,
    input  RegWrite_MEM, MemtoReg_MEM, mthi_MEM, mtlo_MEM, mfhi_MEM, mflo_MEM,
    input  HiLoWrite_MEM, ALUResult_MEM, MemReadData_MEM, Product_MEM,
    input  WriteRegister_MEM,
    output WriteData, WriteRegister_WB, RegWrite_WB, HI, LO
  );

endinterface

// File: rtl/write_back_stage.sv
// write_back_stage
//   Holds the MEM/WB pipeline register and the architectural HI/LO pair.
//   It produces the register-file write port (data, index, enable).
//   Ports:
//     Clk   : pipeline clock, rising-edge active
//     Rst   : asynchronous active-high reset; clears MEM/WB, HI and LO
//     wbBus : write_back_stage_if.slave. It carries Stall/Flush and the
//             *_MEM fields in, and WriteData, WriteRegister_WB,
//             RegWrite_WB, HI and LO out.
module write_back_stage (
  input  logic              Clk,
  input  logic              Rst,
  write_back_stage_if.slave wbBus
);

  typedef struct packed {
    logic        regWrite;
    logic        memtoReg;
    logic        mthi;
    logic        mtlo;
    logic        mfhi;
    logic        mflo;
    logic        hiLoWrite;
    logic [31:0] aluResult;
    logic [31:0] memReadData;
    logic [63:0] product;
    logic [4:0]  writeRegister;
  } memWbFields_t;

  memWbFields_t memWbQ;
  memWbFields_t memWbNext;
  memWbFields_t memFields;

  logic [31:0] hiQ;
  logic [31:0] loQ;
  logic [31:0] hiNext;
  logic [31:0] loNext;

  // Gather the MEM-side fields into one record so that the register update
  // can treat them as a single unit.
  always_comb begin
    memFields               = '0;
    memFields.regWrite      = wbBus.RegWrite_MEM;
    memFields.memtoReg      = wbBus.MemtoReg_MEM;
    memFields.mthi          = wbBus.mthi_MEM;
    memFields.mtlo          = wbBus.mtlo_MEM;
    memFields.mfhi          = wbBus.mfhi_MEM;
    memFields.mflo          = wbBus.mflo_MEM;
    memFields.hiLoWrite     = wbBus.HiLoWrite_MEM;
    memFields.aluResult     = wbBus.ALUResult_MEM;
    memFields.memReadData   = wbBus.MemReadData_MEM;
    memFields.product       = wbBus.Product_MEM;
    memFields.writeRegister = wbBus.WriteRegister_MEM;
  end

  // Next MEM/WB contents. Flush wins over Stall. A bubble is all zeros,
  // so it carries no GPR write and no HI/LO write.
  always_comb begin
    memWbNext = memWbQ;
    if (wbBus.Flush) begin
      memWbNext = '0;
    end else if (!wbBus.Stall) begin
      memWbNext = memFields;
    end
  end

  // MEM/WB register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      memWbQ <= '0;
    end else begin
      memWbQ <= memWbNext;
    end
  end

  // The instruction sitting in WB commits to HI/LO at the closing edge.
  // While stalled it commits again each edge. That is harmless because the
  // write is idempotent. A full product write outranks mthi/mtlo. mthi and
  // mtlo together load both halves from the ALU result.
  always_comb begin
    hiNext = hiQ;
    loNext = loQ;
    if (memWbQ.hiLoWrite) begin
      hiNext = memWbQ.product[63:32];
      loNext = memWbQ.product[31:0];
    end else begin
      if (memWbQ.mthi) begin
        hiNext = memWbQ.aluResult;
      end
      if (memWbQ.mtlo) begin
        loNext = memWbQ.aluResult;
      end
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hiQ <= '0;
      loQ <= '0;
    end else begin
      hiQ <= hiNext;
      loQ <= loNext;
    end
  end

  // GPR write data. An mfhi/mflo reads the live HI/LO registers. Any
  // HI/LO producer ahead of it has already committed on the edge that
  // brought the move into WB, so no bypass path is needed.
  always_comb begin
    wbBus.WriteData = memWbQ.aluResult;
    if (memWbQ.mfhi) begin
      wbBus.WriteData = hiQ;
    end else if (memWbQ.mflo) begin
      wbBus.WriteData = loQ;
    end else if (memWbQ.memtoReg) begin
      wbBus.WriteData = memWbQ.memReadData;
    end
  end

  // Register $0 is hard-wired to zero, so writes to it are dropped here.
  always_comb begin
    wbBus.RegWrite_WB      = memWbQ.regWrite && (memWbQ.writeRegister != 5'd0);
    wbBus.WriteRegister_WB = memWbQ.writeRegister;
    wbBus.HI               = hiQ;
    wbBus.LO               = loQ;
  end

endmodule

// File: doc/write_back_stage.md
WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL use these ports:
- Clk  input  1  pipeline clock, rising-edge active
- Rst  input  1  asynchronous active-high reset
- Stall  input  1  hold the MEM/WB register
- Flush  input  1  load a bubble into the MEM/WB register
- RegWrite_MEM  input  1  instruction in MEM writes a GPR
- MemtoReg_MEM  input  1  select memory load data for the GPR write
- mthi_MEM  input  1  instruction is mthi
- mtlo_MEM  input  1  instruction is mtlo
- mfhi_MEM  input  1  instruction is mfhi
- mflo_MEM  input  1  instruction is mflo
- HiLoWrite_MEM  input  1  mult/madd result to be committed to HI/LO
- ALUResult_MEM  input  32  ALU result, or the rs value for mthi/mtlo
- MemReadData_MEM  input  32  data-memory load data
- Product_MEM  input  64  64-bit HI:LO product
- WriteRegister_MEM  input  5  destination GPR index
- WriteData  output  32  GPR write data to the register file
- WriteRegister_WB  output  5  GPR write index to the register file
- RegWrite_WB  output  1  GPR write enable to the register file
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Function
REQ-003 The MEM/WB register SHALL capture all *_MEM inputs on the rising Clk edge when Stall=0 and Flush=0.
- Latency: exactly one cycle from the inputs to the WB outputs.
REQ-004 On an edge with Flush=1, the register SHALL load a bubble: all control bits 0, all data fields 0, destination index 0.
- Flush has priority over Stall.
REQ-005 On an edge with Stall=1 and Flush=0, the register SHALL hold its contents.
- All outputs stay unchanged.
- A repeated GPR or HI/LO write of the held instruction is permitted because it is idempotent.
REQ-006 WriteData SHALL be combinational from the latched fields, using the first matching rule:
- mfhi latched: WriteData = HI.
- else mflo latched: WriteData = LO.
- else MemtoReg latched: WriteData = MemReadData.
- else: WriteData = ALUResult.
REQ-007 RegWrite_WB SHALL be 1 only when the latched RegWrite=1 and the latched WriteRegister is nonzero.
- Writes to $0 are suppressed.
REQ-008 WriteRegister_WB SHALL equal the latched WriteRegister.
REQ-009 HI/LO SHALL update on a rising Clk edge according to the instruction currently latched in WB, in priority order:
- HiLoWrite latched: HI = Product[63:32], LO = Product[31:0].
- else mthi latched: HI = ALUResult, LO unchanged.
- else mtlo latched: LO = ALUResult, HI unchanged.
- mthi and mtlo both latched: HI and LO both receive ALUResult.
REQ-010 HI/LO SHALL NOT change while the WB register holds a bubble.
REQ-011 An mfhi/mflo in WB on the cycle after an mthi/mtlo/HiLoWrite left WB SHALL observe the updated HI/LO without any extra bypass.
REQ-012 HI and LO SHALL be directly readable on the HI/LO outputs at all times.

Reset
REQ-013 Asserting Rst SHALL immediately, independent of Clk, clear every MEM/WB field, HI and LO.
- Resulting outputs: WriteData=0, WriteRegister_WB=0, RegWrite_WB=0, HI=0, LO=0.
REQ-014 While Rst=1, Stall, Flush and all data inputs SHALL be ignored.
REQ-015 After Rst deasserts, the first rising edge SHALL capture the inputs normally.
REQ-016 Reset asserted mid-stall or mid-operation SHALL discard the in-flight instruction with no GPR or HI/LO write.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Load: RegWrite=1, MemtoReg=1, MemReadData=0xDEADBEEF, ALUResult=0x10, WriteRegister=8 -> one edge later WriteData=0xDEADBEEF, WriteRegister_WB=8, RegWrite_WB=1.
- $0 suppression: RegWrite=1, WriteRegister=0, ALUResult=5 -> RegWrite_WB=0.
- HI/LO sequence: HiLoWrite=1 with Product=0x00000001_80000000, then mfhi next (RegWrite=1, WriteRegister=9) -> HI=1, LO=0x80000000, mfhi cycle WriteData=0x00000001.
- Priority: HiLoWrite=1 and mthi=1 with ALUResult=0x55, Product=0x2_3 -> HI=2, LO=3.
- Stall/flush: Stall=1 for 3 edges holds outputs constant; Flush=1 together with Stall=1 -> RegWrite_WB=0 and WriteData=0 after the edge, HI/LO unchanged.
- Async reset: Rst pulsed between edges after mthi ALUResult=0x1234 is loaded -> all outputs 0 immediately, HI=0, and HI stays 0 at the next edge.
